axi_ram_resp: RTL and testbench

//  AXI4 slave memory: the responder end of the system's m_axi_* DDR master port (simulation DDR model / BRAM-backed ext memory).

---
 rtl/axi_ram_resp_if.sv | 63 ++++++
 rtl/axi_ram_resp.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_ram_resp.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_resp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_ram_resp_if                                                            |
// | AXI4 subset bundle (AW/W/B/AR/R) between a DDR-style master and the RAM.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface axi_ram_resp_if #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32
);
    logic [AXI_ID_W-1:0]     s_axi_awid;
    logic [AXI_ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]              s_axi_awlen;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [AXI_DATA_W-1:0]   s_axi_wdata;
    logic [AXI_DATA_W/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [AXI_ID_W-1:0]     s_axi_bid;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [AXI_ID_W-1:0]     s_axi_arid;
    logic [AXI_ADDR_W-1:0]   s_axi_araddr;
    logic [7:0]              s_axi_arlen;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [AXI_ID_W-1:0]     s_axi_rid;
    logic [AXI_DATA_W-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rlast;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_ram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_ram_resp                                                               |
// | AXI4 slave RAM with independent single-outstanding read/write INCR engines.|
// | Optional: AXI_RAM_RESP_DECERR_EN answers addresses above storage w/ DECERR.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module axi_ram_resp #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 20
) (
    input  wire logic     clk,
    input  wire logic     rst,
    axi_ram_resp_if.slave s_axi
);
    localparam int         c_BYTES    = AXI_DATA_W / 8;
    localparam int         c_BYTE_LSB = $clog2(c_BYTES);
    localparam int         c_WORD_W   = AXI_ADDR_W - c_BYTE_LSB;
    localparam int         c_IDX_W    = MEM_ADDR_W - c_BYTE_LSB;
    localparam int         c_DEPTH    = 1 << c_IDX_W;
    localparam logic [1:0] c_OKAY     = 2'b00;
    localparam logic [1:0] c_DECERR   = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    logic [AXI_DATA_W-1:0] r_mem [c_DEPTH];

    // Write engine state
    w_state_t              r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [AXI_ID_W-1:0]   r_bid;
    logic [c_WORD_W-1:0]   r_waddr;
    logic [7:0]            r_wcount;
    logic                  r_werr;

    // Read engine state
    r_state_t              r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [AXI_ID_W-1:0]   r_rid;
    logic [AXI_DATA_W-1:0] r_rdata;
    logic [c_WORD_W-1:0]   r_raddr;
    logic [7:0]            r_rcount;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_werr;
    logic                  w_rerr;
    logic                  w_mem_we;
    logic [c_IDX_W-1:0]    w_widx;
    logic [c_IDX_W-1:0]    w_ridx;
    logic                  w_unused;

    assign w_aw_hs = s_axi.s_axi_awvalid && r_awready;
    assign w_w_hs  = s_axi.s_axi_wvalid && r_wready;
    assign w_ar_hs = s_axi.s_axi_arvalid && r_arready;
    assign w_widx  = r_waddr[c_IDX_W-1:0];
    assign w_ridx  = r_raddr[c_IDX_W-1:0];

`ifdef AXI_RAM_RESP_DECERR_EN
    // Decode is per beat: the running word address is kept at full AXI width.
    assign w_werr   = (r_waddr >> c_IDX_W) != '0;
    assign w_rerr   = (r_raddr >> c_IDX_W) != '0;
    assign w_unused = ^{s_axi.s_axi_awaddr[c_BYTE_LSB-1:0], s_axi.s_axi_araddr[c_BYTE_LSB-1:0]};
`else
    // Upper address bits alias onto the backed storage.
    assign w_werr   = 1'b0;
    assign w_rerr   = 1'b0;
    assign w_unused = ^{s_axi.s_axi_awaddr[c_BYTE_LSB-1:0], s_axi.s_axi_araddr[c_BYTE_LSB-1:0],
                        r_waddr >> c_IDX_W, r_raddr >> c_IDX_W};
`endif

    // Reset only blocks the strobe; stored contents survive reset.
    assign w_mem_we = !rst && w_w_hs && !w_werr;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (s_axi.s_axi_wstrb[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_bid     <= '0;
            r_waddr   <= '0;
            r_wcount  <= 8'd0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid     <= s_axi.s_axi_awid;
                        r_waddr   <= s_axi.s_axi_awaddr[AXI_ADDR_W-1:c_BYTE_LSB];
                        r_wcount  <= s_axi.s_axi_awlen;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr  <= r_waddr + 1'b1;
                        r_wcount <= r_wcount - 1'b1;
                        if (w_werr) begin
                            r_werr <= 1'b1;
                        end
                        // Burst length comes from awlen alone; there is no wlast input.
                        if (r_wcount == 8'd0) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_werr) ? c_DECERR : c_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= c_OKAY;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_raddr   <= '0;
            r_rcount  <= 8'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= s_axi.s_axi_arid;
                        r_raddr   <= s_axi.s_axi_araddr[AXI_ADDR_W-1:c_BYTE_LSB];
                        r_rcount  <= s_axi.s_axi_arlen;
                        r_arready <= 1'b0;
                        r_rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Non-blocking read beside the write port gives read-before-write.
                    r_rdata  <= w_rerr ? '0 : r_mem[w_ridx];
                    r_rresp  <= w_rerr ? c_DECERR : c_OKAY;
                    r_rlast  <= (r_rcount == 8'd0);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi.s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr  <= r_raddr + 1'b1;
                            r_rcount <= r_rcount - 1'b1;
                            r_rstate <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi.s_axi_awready = r_awready;
    assign s_axi.s_axi_wready  = r_wready;
    assign s_axi.s_axi_bid     = r_bid;
    assign s_axi.s_axi_bresp   = r_bresp;
    assign s_axi.s_axi_bvalid  = r_bvalid;
    assign s_axi.s_axi_arready = r_arready;
    assign s_axi.s_axi_rid     = r_rid;
    assign s_axi.s_axi_rdata   = r_rdata;
    assign s_axi.s_axi_rresp   = r_rresp;
    assign s_axi.s_axi_rlast   = r_rlast;
    assign s_axi.s_axi_rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_ram_resp                                                            |
// | Random + directed AXI traffic against a byte-array memory model.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_axi_ram_resp;
    localparam int ID_W   = 1;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int MEM_W  = 20;
    localparam int unsigned MEMB = 1 << MEM_W;
`ifdef AXI_RAM_RESP_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_ram_resp_if #(.AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W)) bus ();

    axi_ram_resp #(
        .AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .AXI_DATA_W(DATA_W), .MEM_ADDR_W(MEM_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    typedef struct {
        logic [31:0]     data;
        logic [31:0]     mask;
        logic            last;
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } rexp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } bexp_t;

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [int unsigned];
    rexp_t rq[$];
    bexp_t bq[$];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    bit bready_hold = 1'b0;
    bit rready_rand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // INCR beat address, wrapping at the AXI address width
    function automatic int unsigned beat_addr(input int unsigned start, input int i);
        return ((start & 32'hFFFF_FFFC) + 32'(4 * i)) & 32'h00FF_FFFF;
    endfunction

    function automatic bit beat_err(input int unsigned a);
        return DECERR && ((a >> MEM_W) != 0);
    endfunction

    task automatic do_write(input int unsigned addr, input int len, input logic [ID_W-1:0] id,
                            input int nsend, input bit gaps);
        int  n;
        bit  err;
        bexp_t be;
        int unsigned a;
        err = 1'b0;
        for (int i = 0; i <= len; i++) err |= beat_err(beat_addr(addr, i));
        if (nsend == len + 1) begin
            be.id   = id;
            be.resp = err ? 2'b11 : 2'b00;
            bq.push_back(be);
        end
        @(posedge clk); #1;
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr[23:0];
        bus.s_axi_awlen   = len[7:0];
        bus.s_axi_awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.s_axi_awready) break;
            if (++n > 2000) begin total++; bad++; $display("FAIL aw_timeout: awready=0 expected 1"); break; end
        end
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.s_axi_wdata  = wd[i];
            bus.s_axi_wstrb  = ws[i];
            bus.s_axi_wvalid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (bus.s_axi_wready) break;
                if (++n > 2000) begin total++; bad++; $display("FAIL w_timeout: wready=0 expected 1"); break; end
            end
            a = beat_addr(addr, i);
            if (!beat_err(a)) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[(a + b) % MEMB] = wd[i][8*b +: 8];
            end
            @(posedge clk); #1;
            bus.s_axi_wvalid = 1'b0;
        end
    endtask

    task automatic do_read(input int unsigned addr, input int len, input logic [ID_W-1:0] id,
                           input bit chk_lat);
        int n;
        int unsigned a, idx;
        rexp_t e;
        for (int i = 0; i <= len; i++) begin
            a      = beat_addr(addr, i);
            e.data = '0;
            e.mask = '0;
            e.last = (i == len);
            e.id   = id;
            e.resp = beat_err(a) ? 2'b11 : 2'b00;
            if (beat_err(a)) begin
                e.mask = 32'hFFFF_FFFF;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    idx = (a + b) % MEMB;
                    if (ref_mem.exists(idx)) begin
                        e.data[8*b +: 8] = ref_mem[idx];
                        e.mask[8*b +: 8] = 8'hFF;
                    end
                end
            end
            rq.push_back(e);
        end
        @(posedge clk); #1;
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr[23:0];
        bus.s_axi_arlen   = len[7:0];
        bus.s_axi_arvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.s_axi_arready) break;
            if (++n > 2000) begin total++; bad++; $display("FAIL ar_timeout: arready=0 expected 1"); break; end
        end
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        if (chk_lat) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.s_axi_rvalid && n < 10);
            chk("r_latency", 64'(n), 64'd2);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 5000) begin @(posedge clk); n++; end
        if (n >= 5000) begin
            total++; bad++;
            $display("FAIL drain_timeout: r_left=%0d b_left=%0d expected 0", rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Ready generators
    initial begin
        bus.s_axi_bready = 1'b0;
        bus.s_axi_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.s_axi_bready = bready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.s_axi_rready = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor: a handshake lands on the next edge when valid&&ready here
    initial begin
        rexp_t e;
        bexp_t be;
        forever begin
            @(negedge clk);
            if (!rst && bus.s_axi_rvalid && bus.s_axi_rready) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL r_unexpected: got beat data=%0h, expected none", bus.s_axi_rdata);
                end else begin
                    e = rq.pop_front();
                    if (e.mask != 0) chk("rdata", 64'(bus.s_axi_rdata & e.mask), 64'(e.data & e.mask));
                    chk("rid",   64'(bus.s_axi_rid),   64'(e.id));
                    chk("rresp", 64'(bus.s_axi_rresp), 64'(e.resp));
                    chk("rlast", 64'(bus.s_axi_rlast), 64'(e.last));
                end
            end
            if (!rst && bus.s_axi_bvalid && bus.s_axi_bready) begin
                if (bq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected: got bvalid bid=%0h, expected none", bus.s_axi_bid);
                end else begin
                    be = bq.pop_front();
                    chk("bid",   64'(bus.s_axi_bid),   64'(be.id));
                    chk("bresp", 64'(bus.s_axi_bresp), 64'(be.resp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned addr;
        int len;
        bus.s_axi_awid = '0;  bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;  bus.s_axi_wvalid = 1'b0;
        bus.s_axi_arid = '0;  bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_awready", 64'(bus.s_axi_awready), 64'd1);
        chk("rst_arready", 64'(bus.s_axi_arready), 64'd1);
        chk("rst_wready",  64'(bus.s_axi_wready),  64'd0);
        chk("rst_bvalid",  64'(bus.s_axi_bvalid),  64'd0);
        chk("rst_rvalid",  64'(bus.s_axi_rvalid),  64'd0);
        chk("rst_rlast",   64'(bus.s_axi_rlast),   64'd0);
        chk("rst_rdata",   64'(bus.s_axi_rdata),   64'd0);

        // Single beat write/read with latency check
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h10, 0, 1'b0, 1, 1'b0); drain();
        do_read(32'h10, 0, 1'b0, 1'b1);     drain();

        // Byte-strobe merge
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(32'h20, 0, 1'b0, 1, 1'b0); drain();
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        do_write(32'h20, 0, 1'b0, 1, 1'b0); drain();
        do_read(32'h20, 0, 1'b0, 1'b0);     drain();

        // 16-beat burst, id=1, rready toggling
        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        rready_rand = 1'b1;
        do_write(32'h100, 15, 1'b1, 16, 1'b1); drain();
        do_read(32'h100, 15, 1'b1, 1'b0);      drain();
        rready_rand = 1'b0;

        // B held off by bready low
        bready_hold = 1'b1;
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write(32'h200, 0, 1'b1, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_bvalid",  64'(bus.s_axi_bvalid),  64'd1);
            chk("hold_bid",     64'(bus.s_axi_bid),     64'd1);
            chk("hold_bresp",   64'(bus.s_axi_bresp),   64'd0);
            chk("hold_awready", 64'(bus.s_axi_awready), 64'd0);
        end
        bready_hold = 1'b0;
        drain();

        // Concurrent write and read on disjoint areas
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        rready_rand = 1'b1;
        fork
            do_write(32'h4000, 7, 1'b0, 8, 1'b1);
            do_read(32'h100, 15, 1'b1, 1'b0);
        join
        drain();
        do_read(32'h4000, 7, 1'b0, 1'b0); drain();
        rready_rand = 1'b0;

        // Reset in the middle of a write burst
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
        do_write(32'h6000, 7, 1'b0, 8, 1'b0); drain();
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h6000, 7, 1'b1, 3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_bvalid",  64'(bus.s_axi_bvalid),  64'd0);
            chk("abort_wready",  64'(bus.s_axi_wready),  64'd0);
            chk("abort_awready", 64'(bus.s_axi_awready), 64'd1);
        end
        do_read(32'h6000, 7, 1'b0, 1'b0); drain();

        // Upper address bits: alias or DECERR, including a burst crossing the top
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(32'h40, 0, 1'b0, 1, 1'b0);       drain();
        do_read(32'h100040, 0, 1'b0, 1'b0);       drain();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(32'h0FFFF8, 3, 1'b1, 4, 1'b0);   drain();
        do_read(32'h0FFFF8, 3, 1'b1, 1'b0);       drain();
        do_read(32'h0, 1, 1'b0, 1'b0);            drain();

        // Maximum burst length
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        rready_rand = 1'b1;
        do_write(32'h8000, 255, 1'b0, 256, 1'b0); drain();
        do_read(32'h8000, 255, 1'b1, 1'b0);       drain();

        // Random traffic
        for (int t = 0; t < 20; t++) begin
            len  = $urandom_range(0, 7);
            addr = 32'hA000 + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) addr |= 32'h100000 * $urandom_range(1, 15);
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write(addr, len, 1'($urandom), len + 1, 1'($urandom));
            drain();
            addr = addr + 4 * $urandom_range(0, 3);
            do_read(addr, $urandom_range(0, 7), 1'($urandom), 1'b0);
            drain();
        end
        rready_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
